// File: rtl/asteroids_pkg.sv
// Shared constants and types for the asteroids video pipeline.
package asteroids_pkg;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned COLOR_W  = 3;
    localparam int unsigned SCREEN_W = 320;
    localparam int unsigned SCREEN_H = 240;

    localparam logic [COLOR_W-1:0] COLOR_BLACK   = 3'b000;
    localparam logic [COLOR_W-1:0] COLOR_BLUE    = 3'b001;
    localparam logic [COLOR_W-1:0] COLOR_GREEN   = 3'b010;
    localparam logic [COLOR_W-1:0] COLOR_CYAN    = 3'b011;
    localparam logic [COLOR_W-1:0] COLOR_RED     = 3'b100;
    localparam logic [COLOR_W-1:0] COLOR_MAGENTA = 3'b101;
    localparam logic [COLOR_W-1:0] COLOR_YELLOW  = 3'b110;
    localparam logic [COLOR_W-1:0] COLOR_WHITE   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_GRANT = 2'd2,
        ST_SERVE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/clear_sweeper.sv
// Row-major cx/cy scan counter for the frame clear sweep.
module clear_sweeper
    import asteroids_pkg::*;
#(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               step,
    output logic [COORD_W-1:0] cx,
    output logic [COORD_W-1:0] cy,
    output logic               last
);

    logic row_end;

    always_comb begin
        row_end = (cx == COORD_W'(WIDTH - 1));
        last    = row_end && (cy == COORD_W'(HEIGHT - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cx <= '0;
            cy <= '0;
        end else if (start) begin
            cx <= '0;
            cy <= '0;
        end else if (step) begin
            if (row_end) begin
                cx <= '0;
                cy <= last ? '0 : cy + 1'b1;
            end else begin
                cx <= cx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_draw_scheduler.sv
// Per-frame owner of the VGA adapter pixel port: clear sweep, then fixed-order
// grants to the draw engines through a registered pixel mux.
module frame_draw_scheduler
    import asteroids_pkg::*;
#(
    parameter int unsigned         N_REQ       = 4,
    parameter int unsigned         SCREEN_W    = asteroids_pkg::SCREEN_W,
    parameter int unsigned         SCREEN_H    = asteroids_pkg::SCREEN_H,
    parameter logic [COLOR_W-1:0]  CLEAR_COLOR = COLOR_BLACK,
    parameter int unsigned         TIMEOUT     = 4096
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       frame_tick,
    input  logic [N_REQ-1:0]           req_en,
    output logic [N_REQ-1:0]           req_start,
    input  logic [N_REQ-1:0]           req_done,
    input  logic [N_REQ*COORD_W-1:0]   req_x,
    input  logic [N_REQ*COORD_W-1:0]   req_y,
    input  logic [N_REQ*COLOR_W-1:0]   req_color,
    input  logic [N_REQ-1:0]           req_plot,
    output logic [COORD_W-1:0]         x,
    output logic [COORD_W-1:0]         y,
    output logic [COLOR_W-1:0]         color,
    output logic                       writeEn,
    output logic                       busy,
    output logic                       overrun,
    output logic                       timeout_err
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    sched_state_t       state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [WD_W-1:0]    wd, wd_n;
    logic               sweep_start, sweep_step, sweep_last;
    logic               timeout_hit, advance;
    logic [COORD_W-1:0] cx, cy;
    logic [COORD_W-1:0] sel_x, sel_y;
    logic [COLOR_W-1:0] sel_color;
    logic               sel_plot;

    clear_sweeper #(
        .WIDTH  (SCREEN_W),
        .HEIGHT (SCREEN_H)
    ) u_sweeper (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (sweep_start),
        .step    (sweep_step),
        .cx      (cx),
        .cy      (cy),
        .last    (sweep_last)
    );

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        wd_n        = wd;
        sweep_start = 1'b0;
        sweep_step  = 1'b0;
        timeout_hit = 1'b0;
        advance     = 1'b0;
        req_start   = '0;
        case (state)
            ST_IDLE: begin
                if (frame_tick) begin
                    sweep_start = 1'b1;
                    state_n     = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                sweep_step = 1'b1;
                if (sweep_last) begin
                    idx_n   = '0;
                    state_n = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (req_en[idx]) begin
                    req_start[idx] = 1'b1;
                    wd_n           = '0;
                    state_n        = ST_SERVE;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_SERVE: begin
                wd_n = wd + 1'b1;
                if (req_done[idx]) begin
                    advance = 1'b1;
                end else if (wd == WD_W'(TIMEOUT - 1)) begin
                    advance     = 1'b1;
                    timeout_hit = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // Skips, dones and timeouts all leave through the same index step.
        if (advance) begin
            if (idx == IDX_W'(N_REQ - 1)) begin
                state_n = ST_IDLE;
            end else begin
                idx_n   = idx + 1'b1;
                state_n = ST_GRANT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            wd          <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            wd    <= wd_n;
            if (frame_tick && (state != ST_IDLE)) overrun <= 1'b1;
            if (timeout_hit) timeout_err <= 1'b1;
        end
    end

    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_color = '0;
        sel_plot  = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_x     = req_x[i*COORD_W +: COORD_W];
                sel_y     = req_y[i*COORD_W +: COORD_W];
                sel_color = req_color[i*COLOR_W +: COLOR_W];
                sel_plot  = req_plot[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x       <= '0;
            y       <= '0;
            color   <= '0;
            writeEn <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    x       <= cx;
                    y       <= cy;
                    color   <= CLEAR_COLOR;
                    writeEn <= 1'b1;
                end
                ST_SERVE: begin
                    x       <= sel_x;
                    y       <= sel_y;
                    color   <= sel_color;
                    writeEn <= sel_plot;
                end
                default: writeEn <= 1'b0;
            endcase
        end
    end

    always_comb busy = (state != ST_IDLE);

endmodule

// File: doc/frame_draw_scheduler.md
# frame_draw_scheduler

Sequences every video frame's writes into the single VGA adapter pixel port. On each frame tick it clears the 320x240 buffer, then grants the port in fixed order to up to N draw engines (ship, asteroids, bullets, score). The granted engine's pixel bus is forwarded to the adapter through a registered mux. It sits between the draw modules and `vga_adapter` and replaces the direct `draw_ship`-to-adapter wiring.

## Interface
- `N_REQ`, 4: number of draw requesters; index 0 is served first.
- `SCREEN_W`, 320: clear-sweep width.
- `SCREEN_H`, 240: clear-sweep height.
- `CLEAR_COLOR`, 3'b000: colour written during the clear sweep.
- `TIMEOUT`, 4096: maximum SERVE cycles per requester.
- `clk`  in  1  system clock (50 MHz).
- `reset_n`  in  1  asynchronous reset, active-low.
- `frame_tick`  in  1  single-cycle pulse in `clk` domain that starts a frame.
- `req_en`  in  N_REQ  per-requester enable, sampled at GRANT.
- `req_start`  out  N_REQ  one-cycle start pulse to requester i.
- `req_done`  in  N_REQ  requester i finished; sampled only while serving i.
- `req_x`  in  N_REQ*10  packed x, slice i = [10i+9:10i].
- `req_y`  in  N_REQ*10  packed y.
- `req_color`  in  N_REQ*3  packed colour.
- `req_plot`  in  N_REQ  write strobe per requester.
- `x`, `y`  out  10 each  to adapter.
- `color`  out  3  to adapter.
- `writeEn`  out  1  to adapter plot.
- `busy`  out  1  high in every state except IDLE.
- `overrun`  out  1  sticky; a frame_tick arrived while busy.
- `timeout_err`  out  1  sticky; a requester hit TIMEOUT.

## Operation
- States: IDLE, CLEAR, GRANT, SERVE.
- IDLE:
  - On `frame_tick`, load cx=0, cy=0 and go to CLEAR.
- CLEAR:
  - Each cycle, emit one pixel (cx, cy, CLEAR_COLOR, plot=1) in row-major order.
  - cx wraps at SCREEN_W-1 and increments cy.
  - After pixel (319,239), set idx=0 and go to GRANT. The sweep is exactly SCREEN_W*SCREEN_H = 76800 cycles.
- GRANT:
  - If `req_en[idx]`=1, pulse `req_start[idx]` for this one cycle, clear the watchdog and go to SERVE.
  - Otherwise skip the requester in one cycle with no start pulse.
  - After idx = N_REQ-1, return to IDLE.
- SERVE:
  - Forward slice idx of `req_x/req_y/req_color/req_plot`. Other requesters' buses are ignored.
  - On `req_done[idx]`=1, advance idx and go to GRANT (or IDLE if last). A pixel presented in the done cycle is still forwarded.
  - If the watchdog reaches TIMEOUT with no done, set `timeout_err` and advance the same way.
- `frame_tick` outside IDLE is dropped (never queued) and sets `overrun`.
- `frame_tick` in IDLE with all `req_en`=0 still performs the clear.
- Sticky flags clear only on reset.

## Timing
- Reset (async, `reset_n`=0): state IDLE; `x`, `y`, `color`, `writeEn`, `req_start`, `busy`, `overrun`, `timeout_err` all 0; counters 0. Reset mid-frame abandons the frame immediately.
- Output latency: the adapter outputs are registered, so they appear 1 cycle after the state or requester input that produced them.
- Clear pixel (0,0) is on the outputs 2 cycles after the `frame_tick` cycle.
- `writeEn`=0 in IDLE, in GRANT, and in SERVE whenever the served `req_plot`=0.
- Requester contract:
  - Do not assert done in the start cycle; done is first sampled one cycle after `req_start`.
  - Hold pixel outputs valid while plot=1.
- `busy` rises the cycle after `frame_tick` and falls the cycle after the last requester's done.

## Structure
- Shared package `asteroids_pkg`: state encoding, `SCREEN_W`/`SCREEN_H`, colour constants (`COLOR_BLACK`=3'b000, etc.), `COORD_W`=10.
- One sub-module `clear_sweeper`: cx/cy counters, with `start`, `step` and `last` signals and the pixel coordinates as outputs.
- The FSM, grant index, watchdog and output mux live in the top module.

## Test plan
- Clear sweep:
  - Stimulus: reset, then `frame_tick`, all `req_en`=0.
  - Response: exactly 76800 `writeEn` pulses, colour 0. First pixel (0,0), pixel 320 is (0,1), last is (319,239); then `busy`=0.
- Grant sequence:
  - Stimulus: `req_en`=4'b1111; each model plots 3 pixels, then asserts done.
  - Response: `req_start` pulses in order 0,1,2,3, one GRANT cycle apart from the previous done. Exactly 12 requester pixels reach the adapter with the correct coordinates and colours.
- Skip:
  - Stimulus: `req_en`=4'b0101.
  - Response: starts only for 0 and 2; requesters 1 and 3 each cost 1 cycle with `writeEn`=0.
- Overrun:
  - Stimulus: `frame_tick` 100 cycles into CLEAR.
  - Response: `overrun`=1; the sweep continues unchanged; no second frame.
- Timeout:
  - Stimulus: requester 1 never asserts done, TIMEOUT=16.
  - Response: after 16 SERVE cycles, `timeout_err`=1 and requester 2 is started.
- Reset mid-SERVE:
  - Stimulus: `reset_n`=0 for 1 cycle while requester 2 is plotting.
  - Response: all outputs 0 immediately; the next `frame_tick` restarts with the clear at (0,0).
